// File: rtl/manchester_encoder.sv
// manchester_encoder
//   Frame-level Manchester transmitter. Accepts a parallel word over a
//   valid/ready handshake, sends PREAMBLE_BITS '1' bits, then the word
//   MSB-first, then GAP_BITS idle bit periods with the line held low.
//   Line convention: ManchesterCode = data ^ bitCLK, where bitCLK is high
//   during the first half of every preamble/data bit.
//
// Ports
//   osc            in   system clock, rising edge
//   globalReset    in   synchronous active-high reset
//   txData         in   payload word, sampled on the handshake edge
//   txValid        in   payload available
//   txReady        out  word can be accepted (IDLE and not in reset)
//   ManchesterCode out  registered encoded line
//   bitCLK         out  registered half-bit phase (1 = first half)
//   txBusy         out  frame in progress (PREAMBLE, DATA, GAP)
//   frameDone      out  one-cycle pulse on the first GAP cycle
//
// state    | meaning
// IDLE     | line low, waiting for txValid
// PREAMBLE | sending PREAMBLE_BITS '1' bits
// DATA     | sending shift-register MSB, shift left at each bit end
// GAP      | line low for GAP_BITS bit periods, then back to IDLE
module manchester_encoder #(
    parameter int DATA_W        = 8,
    parameter int HALF_PERIOD   = 8,
    parameter int PREAMBLE_BITS = 4,
    parameter int GAP_BITS      = 1
) (
    input  logic              osc,
    input  logic              globalReset,
    input  logic [DATA_W-1:0] txData,
    input  logic              txValid,
    output logic              txReady,
    output logic              ManchesterCode,
    output logic              bitCLK,
    output logic              txBusy,
    output logic              frameDone
);

    localparam int HCW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int MAXA  = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
    localparam int MAXB  = (MAXA > GAP_BITS) ? MAXA : GAP_BITS;
    localparam int BCW0  = $clog2(MAXB + 1);
    localparam int BCW   = (BCW0 < 4) ? 4 : BCW0;

    localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_PERIOD - 1);
    localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BITS - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] GAP_LAST  = BCW'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        GAP
    } stateT;

    stateT             state, stateNext;
    logic [DATA_W-1:0] shiftReg, shiftNext;
    logic [HCW-1:0]    halfCnt, halfNext;
    logic [BCW-1:0]    bitCnt, bitNext;
    logic              phase, phaseNext;   // 0 = first half, 1 = second half

    logic halfEnd;
    logic bitEnd;
    logic lineActive;
    logic lineBit;
    logic bitClkNext;
    logic codeNext;
    logic frameDoneNext;

    assign txReady = (state == IDLE) && !globalReset;
    assign txBusy  = (state != IDLE);

    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        halfNext  = halfCnt;
        bitNext   = bitCnt;
        phaseNext = phase;
        halfEnd   = (halfCnt == HALF_LAST);
        bitEnd    = halfEnd && phase;

        if (state == IDLE) begin
            if (txValid) begin
                stateNext = PREAMBLE;
                shiftNext = txData;
                halfNext  = '0;
                phaseNext = 1'b0;
                bitNext   = '0;
            end
        end else begin
            if (halfEnd) begin
                halfNext  = '0;
                phaseNext = ~phase;
            end else begin
                halfNext  = halfCnt + 1'b1;
            end

            if (bitEnd) begin
                bitNext = bitCnt + 1'b1;
                case (state)
                    PREAMBLE: begin
                        if (bitCnt == PRE_LAST) begin
                            stateNext = DATA;
                            bitNext   = '0;
                        end
                    end
                    DATA: begin
                        shiftNext = shiftReg << 1;
                        if (bitCnt == DATA_LAST) begin
                            stateNext = GAP;
                            bitNext   = '0;
                        end
                    end
                    GAP: begin
                        if (bitCnt == GAP_LAST) begin
                            stateNext = IDLE;
                            bitNext   = '0;
                        end
                    end
                    default: stateNext = IDLE;
                endcase
            end
        end

        // Outputs are registered from the next-state values so the line
        // already shows the first preamble half-bit in the cycle after the
        // handshake edge.
        lineActive    = (stateNext == PREAMBLE) || (stateNext == DATA);
        lineBit       = (stateNext == PREAMBLE) ? 1'b1 : shiftNext[DATA_W-1];
        bitClkNext    = lineActive && !phaseNext;
        codeNext      = lineActive && (lineBit ^ bitClkNext);
        frameDoneNext = (state == DATA) && (stateNext == GAP);
    end

    always_ff @(posedge osc) begin
        if (globalReset) begin
            state          <= IDLE;
            shiftReg       <= '0;
            halfCnt        <= '0;
            bitCnt         <= '0;
            phase          <= 1'b0;
            ManchesterCode <= 1'b0;
            bitCLK         <= 1'b0;
            frameDone      <= 1'b0;
        end else begin
            state          <= stateNext;
            shiftReg       <= shiftNext;
            halfCnt        <= halfNext;
            bitCnt         <= bitNext;
            phase          <= phaseNext;
            ManchesterCode <= codeNext;
            bitCLK         <= bitClkNext;
            frameDone      <= frameDoneNext;
        end
    end

endmodule

// File: tb/tb_manchester_encoder.sv
module tb_manchester_encoder;

    localparam int D = 8;

    logic       osc = 1'b0;
    logic       globalReset;
    logic [7:0] txData;
    logic       txValidA, txValidB;
    logic       rdyA, codeA, clkA, busyA, doneA;
    logic       rdyB, codeB, clkB, busyB, doneB;

    int checks = 0;
    int errors = 0;

    always #5 osc = ~osc;

    // Default-parameter encoder.
    manchester_encoder #(.DATA_W(8), .HALF_PERIOD(8), .PREAMBLE_BITS(4), .GAP_BITS(1)) dutA (
        .osc(osc), .globalReset(globalReset), .txData(txData), .txValid(txValidA),
        .txReady(rdyA), .ManchesterCode(codeA), .bitCLK(clkA), .txBusy(busyA), .frameDone(doneA)
    );

    // Short-bit encoder.
    manchester_encoder #(.DATA_W(8), .HALF_PERIOD(2), .PREAMBLE_BITS(1), .GAP_BITS(1)) dutB (
        .osc(osc), .globalReset(globalReset), .txData(txData), .txValid(txValidB),
        .txReady(rdyB), .ManchesterCode(codeB), .bitCLK(clkB), .txBusy(busyB), .frameDone(doneB)
    );

    task automatic tick;
        @(posedge osc);
        #1;
    endtask

    // {ManchesterCode, bitCLK, txBusy, frameDone, txReady}
    function automatic logic [4:0] obs(input bit sel);
        if (sel) return {codeB, clkB, busyB, doneB, rdyB};
        return {codeA, clkA, busyA, doneA, rdyA};
    endfunction

    // Expected outputs i cycles after the handshake edge (i = 0 is the first
    // preamble cycle), derived from the bit/half-bit arithmetic of a frame.
    function automatic logic [4:0] expVec(input int hp, input int pre, input logic [7:0] w, input int i);
        int   bp;
        int   bi;
        logic first;
        logic b;
        logic code;
        logic bclk;
        bp    = 2 * hp;
        bi    = i / bp;
        first = (i % bp) < hp;
        code  = 1'b0;
        bclk  = 1'b0;
        if (bi < pre + D) begin
            if (bi < pre) b = 1'b1;
            else          b = w[D-1-(bi-pre)];
            bclk = first;
            code = b ^ first;
        end
        return {code, bclk, 1'b1, (i == (pre + D) * bp), 1'b0};
    endfunction

    task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Send one frame on the selected encoder and check every cycle.
    // An extra word may be offered on txValid during indices offerFrom..offerTo;
    // with keepOffer it stays offered into the following IDLE cycle.
    task automatic runFrame(input bit sel, input logic [7:0] w, input int offerFrom, input int offerTo,
                            input logic [7:0] offerWord, input bit keepOffer, input string tag);
        int         hp, pre, gap, bp, total, bi;
        logic [4:0] o;
        logic [7:0] rec;
        hp    = sel ? 2 : 8;
        pre   = sel ? 1 : 4;
        gap   = 1;
        bp    = 2 * hp;
        total = (pre + D + gap) * bp;
        rec   = 8'h00;
        check({tag, "_ready"}, obs(sel) & 5'b00001, 5'b00001);
        txData = w;
        if (sel) txValidB = 1'b1; else txValidA = 1'b1;
        tick();
        if (sel) txValidB = 1'b0; else txValidA = 1'b0;
        txData = 8'($urandom);
        for (int i = 0; i < total; i++) begin
            o = obs(sel);
            check({tag, "_line"}, o, expVec(hp, pre, w, i));
            bi = i / bp;
            if (bi >= pre && bi < pre + D && (i % bp) == hp + hp / 2)
                rec[D-1-(bi-pre)] = o[4];
            if (i == offerFrom) begin
                txData = offerWord;
                if (sel) txValidB = 1'b1; else txValidA = 1'b1;
            end
            if (i == offerTo && !keepOffer) begin
                if (sel) txValidB = 1'b0; else txValidA = 1'b0;
                txData = 8'($urandom);
            end
            tick();
        end
        check({tag, "_idle"}, obs(sel), 5'b00001);
        check({tag, "_recovered"}, {rec[7:3], 3'b000} ^ {3'b000, rec[2:0]} ^ {w[7:3], 3'b000} ^ {3'b000, w[2:0]}, 5'b00000);
        checks++;
        assert (rec === w) else begin
            errors++;
            $error("FAIL %s_word observed=%h expected=%h", tag, rec, w);
        end
    endtask

    initial begin
        logic [7:0] cur, nxt;
        bit         b2b;

        globalReset = 1'b1;
        txValidA    = 1'b0;
        txValidB    = 1'b0;
        txData      = 8'h00;

        // Reset held for 3 cycles: everything low, txReady low.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_A", obs(1'b0), 5'b00000);
            check("reset_B", obs(1'b1), 5'b00000);
        end
        globalReset = 1'b0;
        tick();
        check("post_reset_A", obs(1'b0), 5'b00001);
        check("post_reset_B", obs(1'b1), 5'b00001);

        // Single frame of 0xA5.
        runFrame(1'b0, 8'hA5, -1, -1, 8'h00, 1'b0, "a5");

        // Back-to-back: 0xFF held valid throughout the 0x00 frame.
        runFrame(1'b0, 8'h00, 0, 0, 8'hFF, 1'b1, "b2b_00");
        runFrame(1'b0, 8'hFF, -1, -1, 8'h00, 1'b0, "b2b_ff");

        // txValid pulsed with 0x3C while busy: ignored, frame unaffected.
        runFrame(1'b0, 8'h96, 40, 50, 8'h3C, 1'b0, "busy_pulse");
        check("busy_pulse_after", obs(1'b0), 5'b00001);

        // Short-bit encoder.
        runFrame(1'b1, 8'h81, -1, -1, 8'h00, 1'b0, "hp2_81");
        runFrame(1'b1, 8'($urandom), -1, -1, 8'h00, 1'b0, "hp2_rand");

        // Reset during DATA bit 3: abort, no frameDone afterwards.
        cur = 8'($urandom);
        txData   = cur;
        txValidA = 1'b1;
        tick();
        txValidA = 1'b0;
        for (int i = 0; i < (4 + 3) * 16 + 3; i++) begin
            check("pre_abort", obs(1'b0), expVec(8, 4, cur, i));
            tick();
        end
        globalReset = 1'b1;
        tick();
        check("abort_in_reset", obs(1'b0), 5'b00000);
        globalReset = 1'b0;
        tick();
        check("abort_released", obs(1'b0), 5'b00001);
        for (int i = 0; i < 120; i++) begin
            tick();
            check("abort_quiet", obs(1'b0), 5'b00001);
        end

        // Randomized words, randomly back-to-back.
        nxt = 8'($urandom);
        for (int n = 0; n < 128; n++) begin
            cur = nxt;
            nxt = 8'($urandom);
            b2b = 1'($urandom_range(0, 1));
            if (b2b) runFrame(1'b0, cur, 0, 0, nxt, 1'b1, "rand_b2b");
            else     runFrame(1'b0, cur, -1, -1, 8'h00, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
